// File: rtl/sr_control_mc_pkg.sv
// sr_control_mc_pkg
// Shared definitions for the schoolRISCV multi-cycle control unit:
// RV32 opcode / funct3 / funct7 constants, ALU operation codes, FSM state
// encodings, PC-source and write-data-source codes, the decoded-instruction
// record and the branch-resolution helper.
// Ports: none (package).
package sr_control_mc_pkg;

    // Opcodes
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    // funct3 / funct7
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_OR   = 3'd1;
    localparam logic [2:0] ALU_SRL  = 3'd2;
    localparam logic [2:0] ALU_SLTU = 3'd3;
    localparam logic [2:0] ALU_SUB  = 3'd4;
    localparam logic [2:0] ALU_SLL  = 3'd5;
    localparam logic [2:0] ALU_SLT  = 3'd6;

    // PC source and write-data source selects
    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JAL    = 2'd2;
    localparam logic [1:0] WD_ALU    = 2'd0;
    localparam logic [1:0] WD_IMM    = 2'd1;
    localparam logic [1:0] WD_MEM    = 2'd2;
    localparam logic [1:0] WD_PC4    = 2'd3;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU, CLS_LUI, CLS_BEQ, CLS_BNE, CLS_BLT, CLS_BGE, CLS_JAL, CLS_LW, CLS_SW
    } instrClass_t;

    typedef struct packed {
        instrClass_t cls;
        logic [2:0]  aluCode;
        logic        aluSrc;
        logic [1:0]  wdSrc;
    } decode_t;

    // Latched decode value out of reset: a plain register ADD.
    localparam decode_t DEC_RESET = '{cls: CLS_ALU, aluCode: ALU_ADD, aluSrc: 1'b0, wdSrc: WD_ALU};

    // Branch resolution from the ALU flags; non-branch classes never take.
    function automatic logic branchTaken(input instrClass_t cls, input logic zero, input logic lt);
        case (cls)
            CLS_BEQ: branchTaken = zero;
            CLS_BNE: branchTaken = !zero;
            CLS_BLT: branchTaken = lt;
            CLS_BGE: branchTaken = !lt;
            default: branchTaken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sr_mc_decode.sv
// sr_mc_decode
// Combinational instruction classifier for the multi-cycle control unit.
// Optional feature macro: SR_MC_BRANCH_EXT_EN (adds BLT/BGE as branches).
// Ports:
//   cmdOp[6:0], cmdF3[2:0], cmdF7[6:0] : instruction fields from the IR
//   dec     : class, ALU code, aluSrc and wdSrc for this instruction
//   illegal : encoding not supported by this core
module sr_mc_decode
    import sr_control_mc_pkg::*;
(
    input  logic [6:0] cmdOp,
    input  logic [2:0] cmdF3,
    input  logic [6:0] cmdF7,
    output decode_t    dec,
    output logic       illegal
);

    always_comb begin
        // NOTE: defaults first, so every path through the case assigns
        // every output and no latch is inferred.
        dec     = DEC_RESET;
        illegal = 1'b0;
        case (cmdOp)
            OP_RTYPE: begin
                if (cmdF7 == F7_ZERO) begin
                    case (cmdF3)
                        F3_ADD:  dec.aluCode = ALU_ADD;
                        F3_OR:   dec.aluCode = ALU_OR;
                        F3_SRL:  dec.aluCode = ALU_SRL;
                        F3_SLTU: dec.aluCode = ALU_SLTU;
                        default: illegal = 1'b1;
                    endcase
                end else if (cmdF7 == F7_SUB && cmdF3 == F3_ADD) begin
                    dec.aluCode = ALU_SUB;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_IMM: begin
                dec.aluSrc = 1'b1;
                if (cmdF3 == F3_ADD)                             dec.aluCode = ALU_ADD;
                else if (cmdF3 == F3_SLL && cmdF7 == F7_ZERO)    dec.aluCode = ALU_SLL;
                else                                             illegal = 1'b1;
            end
            OP_LUI: begin
                dec.cls    = CLS_LUI;
                dec.aluSrc = 1'b1;
                dec.wdSrc  = WD_IMM;
            end
            OP_BRANCH: begin
                dec.aluCode = ALU_SUB;
                case (cmdF3)
                    F3_BEQ:  dec.cls = CLS_BEQ;
                    F3_BNE:  dec.cls = CLS_BNE;
`ifdef SR_MC_BRANCH_EXT_EN
                    F3_BLT:  begin dec.cls = CLS_BLT; dec.aluCode = ALU_SLT; end
                    F3_BGE:  begin dec.cls = CLS_BGE; dec.aluCode = ALU_SLT; end
`endif
                    default: illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                dec.cls   = CLS_JAL;
                dec.wdSrc = WD_PC4;
            end
            OP_LOAD: begin
                dec.cls    = CLS_LW;
                dec.aluSrc = 1'b1;
                dec.wdSrc  = WD_MEM;
                illegal    = (cmdF3 != F3_WORD);
            end
            OP_STORE: begin
                dec.cls    = CLS_SW;
                dec.aluSrc = 1'b1;
                illegal    = (cmdF3 != F3_WORD);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/sr_control_mc.sv
// sr_control_mc
// Multi-cycle control unit for the schoolRISCV core. Sequences each
// instruction through FETCH, DECODE, EXEC, MEM and WB, waits on memory ready
// handshakes with a bounded wait counter, and parks in a sticky TRAP state on
// an illegal instruction or a wait timeout.
// Optional feature macro: SR_MC_BRANCH_EXT_EN (BLT/BGE via aluLt).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   cmdOp, cmdF3, cmdF7        : instruction fields from the IR
//   aluZero, aluLt             : ALU flags for branch resolution
//   imemRdy, dmemRdy           : memory ready handshakes
//   imemReq, irWe              : fetch request, IR latch strobe
//   pcWe, pcSrc                : PC update strobe and source
//   regWrite, wdSrc            : register write strobe and data source
//   aluSrc, aluControl         : ALU operand select and operation
//   dmemReq, dmemWe            : data request and write
//   fault, state               : sticky trap flag, current state (debug)
module sr_control_mc
    import sr_control_mc_pkg::*;
#(
    parameter int ALU_W   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       cmdOp,
    input  logic [2:0]       cmdF3,
    input  logic [6:0]       cmdF7,
    input  logic             aluZero,
    input  logic             aluLt,
    input  logic             imemRdy,
    input  logic             dmemRdy,
    output logic             imemReq,
    output logic             irWe,
    output logic             pcWe,
    output logic [1:0]       pcSrc,
    output logic             regWrite,
    output logic             aluSrc,
    output logic [1:0]       wdSrc,
    output logic [ALU_W-1:0] aluControl,
    output logic             dmemReq,
    output logic             dmemWe,
    output logic             fault,
    output logic [2:0]       state
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           stateQ, stateNext;
    decode_t          decNow, decLat;
    logic             decIllegal, decWe;
    logic [CNT_W-1:0] waitCnt;
    logic             waiting, timeoutHit;

    sr_mc_decode uDecode (
        .cmdOp   (cmdOp),
        .cmdF3   (cmdF3),
        .cmdF7   (cmdF7),
        .dec     (decNow),
        .illegal (decIllegal)
    );

    assign state      = stateQ;
    assign waiting    = (stateQ == ST_FETCH && !imemRdy) || (stateQ == ST_MEM && !dmemRdy);
    assign timeoutHit = (TIMEOUT != 0) && (waitCnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ  <= ST_FETCH;
            decLat  <= DEC_RESET;
            waitCnt <= '0;
        end else begin
            stateQ <= stateNext;
            if (decWe)
                decLat <= decNow;
            // Any state change clears the counter, which covers entry to FETCH and MEM.
            if (stateNext != stateQ)
                waitCnt <= '0;
            else if (waiting)
                waitCnt <= waitCnt + 1'b1;
        end
    end

    always_comb begin
        stateNext  = stateQ;
        decWe      = 1'b0;
        imemReq    = 1'b0;
        irWe       = 1'b0;
        pcWe       = 1'b0;
        pcSrc      = PC_PLUS4;
        regWrite   = 1'b0;
        aluSrc     = 1'b0;
        wdSrc      = WD_ALU;
        aluControl = ALU_W'(ALU_ADD);
        dmemReq    = 1'b0;
        dmemWe     = 1'b0;
        fault      = 1'b0;
        // NOTE: outputs are gated by rst_n so nothing (not even imemReq)
        // is driven while reset is held, and strobes vanish the moment it falls.
        if (rst_n) begin
            case (stateQ)
                ST_FETCH: begin
                    imemReq = 1'b1;
                    if (imemRdy) begin
                        irWe      = 1'b1;
                        stateNext = ST_DECODE;
                    end else if (timeoutHit) begin
                        stateNext = ST_TRAP;
                    end
                end
                ST_DECODE: begin
                    decWe     = 1'b1;
                    stateNext = decIllegal ? ST_TRAP : ST_EXEC;
                end
                ST_EXEC: begin
                    aluControl = ALU_W'(decLat.aluCode);
                    aluSrc     = decLat.aluSrc;
                    stateNext  = ST_FETCH;
                    case (decLat.cls)
                        CLS_ALU, CLS_LUI: begin
                            regWrite = 1'b1;
                            wdSrc    = decLat.wdSrc;
                            pcWe     = 1'b1;
                        end
                        CLS_BEQ, CLS_BNE, CLS_BLT, CLS_BGE: begin
                            pcWe = 1'b1;
                            if (branchTaken(decLat.cls, aluZero, aluLt))
                                pcSrc = PC_BRANCH;
                        end
                        CLS_JAL: begin
                            regWrite = 1'b1;
                            wdSrc    = decLat.wdSrc;
                            pcWe     = 1'b1;
                            pcSrc    = PC_JAL;
                        end
                        CLS_LW, CLS_SW: stateNext = ST_MEM;
                        default:        stateNext = ST_TRAP;
                    endcase
                end
                ST_MEM: begin
                    // Keep the address computation on the ALU while the access is pending.
                    aluControl = ALU_W'(decLat.aluCode);
                    aluSrc     = decLat.aluSrc;
                    dmemReq    = 1'b1;
                    dmemWe     = (decLat.cls == CLS_SW);
                    if (dmemRdy) begin
                        if (decLat.cls == CLS_SW) begin
                            pcWe      = 1'b1;
                            stateNext = ST_FETCH;
                        end else begin
                            stateNext = ST_WB;
                        end
                    end else if (timeoutHit) begin
                        stateNext = ST_TRAP;
                    end
                end
                ST_WB: begin
                    regWrite  = 1'b1;
                    wdSrc     = WD_MEM;
                    pcWe      = 1'b1;
                    stateNext = ST_FETCH;
                end
                ST_TRAP: fault = 1'b1;
                default: stateNext = ST_TRAP;
            endcase
        end
    end

endmodule
